// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and default
// parameters for the multi-channel router.
package router_pkg;

  localparam int N_CH_DEF      = 4;
  localparam int TIMEOUT_DEF   = 16;
  localparam int MAX_RETRY_DEF = 2;

  typedef enum logic [3:0] {
    IDLE,
    GET_REQ,
    DNS_QUERY,
    VERIFY_DNS,
    SEND_SERVER,
    AWAIT,
    GET_RESP,
    VERIFY_PKT,
    DELIVER,
    CANCEL,
    FAIL
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// searching upward from i_ptr with wrap-around.
module rr_arbiter
  import router_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [N_CH-1:0] o_gnt,
  output logic [CH_W-1:0] o_idx
);

  // Scan farthest-first so the nearest hit to ptr wins.
  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    j     = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % N_CH;
      if (i_en && i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/router_mc.sv
// router_mc: serves N_CH device channels through one
// DNS port and one server port, one request at a time.
module router_mc
  import router_pkg::*;
#(
  parameter  int N_CH      = N_CH_DEF,
  parameter  int TIMEOUT   = TIMEOUT_DEF,
  parameter  int MAX_RETRY = MAX_RETRY_DEF,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] DeviceReq,
  input  logic            DNSResp,
  input  logic            DNSOk,
  input  logic            ServerResp,
  input  logic            PktOk,
  output logic            DNSReq,
  output logic            ServerReq,
  output logic [N_CH-1:0] DeviceResp,
  output logic [CH_W-1:0] GrantId,
  output logic            Busy,
  output logic            Cancelled,
  output logic            Failed,
  output state_t          State
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t          r_state;
  state_t          w_nxt;
  logic [CH_W-1:0] r_grant;
  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_ptr_nxt;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_retry;
  logic [N_CH-1:0] w_gnt_oh;
  logic [CH_W-1:0] w_gnt_idx;
  logic            w_en;
  logic            w_any;
  logic            w_tmo;
  logic            w_own;
  logic            w_cancel;

  assign w_en  = (r_state == IDLE);
  assign w_any = |w_gnt_oh;
  assign w_tmo = (r_timer == TW'(TIMEOUT - 1));
  assign w_own = DeviceReq[r_grant];

  assign w_cancel = !w_own && (r_state inside {
    GET_REQ, DNS_QUERY, VERIFY_DNS, SEND_SERVER,
    AWAIT, GET_RESP, VERIFY_PKT});

  assign w_ptr_nxt =
    (w_gnt_idx == CH_W'(N_CH - 1)) ? '0
                                    : w_gnt_idx + 1'b1;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req (DeviceReq),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Grant, RR pointer, timeout timer and retry count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      if (w_en && w_any) begin
        r_grant <= w_gnt_idx;
        r_ptr   <= w_ptr_nxt;
      end
      if (r_state inside {GET_REQ, SEND_SERVER})
        r_timer <= '0;
      else if (r_state inside {DNS_QUERY, AWAIT})
        r_timer <= r_timer + 1'b1;
      if (r_state == AWAIT && w_nxt == SEND_SERVER)
        r_retry <= r_retry + 1'b1;
      else if (r_state inside {DELIVER, CANCEL, FAIL})
        r_retry <= '0;
    end
  end

  // Next state; a dropped own request overrides all.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:
        if (w_any) w_nxt = GET_REQ;
      GET_REQ:
        w_nxt = DNS_QUERY;
      DNS_QUERY:
        if (DNSResp)    w_nxt = VERIFY_DNS;
        else if (w_tmo) w_nxt = FAIL;
      VERIFY_DNS:
        w_nxt = DNSOk ? SEND_SERVER : FAIL;
      SEND_SERVER:
        w_nxt = AWAIT;
      AWAIT:
        if (ServerResp) w_nxt = GET_RESP;
        else if (w_tmo) begin
          if (r_retry < RW'(MAX_RETRY))
            w_nxt = SEND_SERVER;
          else
            w_nxt = FAIL;
        end
      GET_RESP:
        w_nxt = VERIFY_PKT;
      VERIFY_PKT:
        w_nxt = PktOk ? DELIVER : FAIL;
      DELIVER, CANCEL, FAIL:
        w_nxt = IDLE;
      default:
        w_nxt = IDLE;
    endcase
    if (w_cancel) w_nxt = CANCEL;
  end

  // Moore output decode of the registered state.
  always_comb begin
    DNSReq     = 1'b0;
    ServerReq  = 1'b0;
    DeviceResp = '0;
    Cancelled  = 1'b0;
    Failed     = 1'b0;
    Busy       = (r_state != IDLE);
    GrantId    = r_grant;
    State      = r_state;
    unique case (1'b1)
      (r_state == DNS_QUERY):   DNSReq    = 1'b1;
      (r_state == SEND_SERVER): ServerReq = 1'b1;
      (r_state == DELIVER):
        DeviceResp = N_CH'(1) << r_grant;
      (r_state == CANCEL):      Cancelled = 1'b1;
      (r_state == FAIL):        Failed    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/router_mc.md
Name: router_mc

Overview:
- Multi-channel successor to the single-device router FSM.
- Serves N_CH device channels through one DNS port and one server port.
- A round-robin arbiter selects which device to serve. Request handling adds bounded timeouts, server retries, explicit DNS and packet verify inputs, and per-channel cancel.
- Sits between the device-side request lines and the shared DNS/server interfaces. One transaction is in flight at a time.

Parameters:
- N_CH, 4, number of device channels (>=2).
- TIMEOUT, 16, cycles allowed in DNS_QUERY or AWAIT without a response (>=2).
- MAX_RETRY, 2, server re-sends after an AWAIT timeout before failing.
- CH_W, $clog2(N_CH), derived local width of the channel index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- DeviceReq  in  N_CH  level request per channel, held until served or withdrawn.
- DNSResp  in  1  DNS response valid.
- DNSOk  in  1  DNS result valid; sampled only in VERIFY_DNS.
- ServerResp  in  1  server response valid.
- PktOk  in  1  packet integrity good; sampled only in VERIFY_PKT.
- DNSReq  out  1  high throughout DNS_QUERY.
- ServerReq  out  1  one-cycle pulse in SEND_SERVER.
- DeviceResp  out  N_CH  one-hot pulse on the granted channel in DELIVER.
- GrantId  out  CH_W  channel being served; holds last value in IDLE.
- Busy  out  1  high in every state except IDLE.
- Cancelled  out  1  one-cycle pulse in CANCEL.
- Failed  out  1  one-cycle pulse in FAIL.
- State  out  state_t  current state, for debug and bench.

Behaviour:
- Reset (synchronous, wins over everything, including mid-transaction):
  - State goes to IDLE and the RR pointer to 0.
  - GrantId, timer and retry counter clear to 0.
  - All outputs are 0.
- Outputs are Moore decodes of the registered state. Only GrantId, the timer, the retry counter and the RR pointer are registered besides state.
- IDLE: if any DeviceReq bit is set, the arbiter grants the first set bit searching from ptr, ptr+1 … wrapping modulo N_CH. On the grant, GrantId latches the winner, ptr becomes winner+1 (wrapping), and state goes to GET_REQ.
- GET_REQ: 1 cycle, then DNS_QUERY; the timer clears on entry.
- DNS_QUERY:
  - DNSResp=1 goes to VERIFY_DNS.
  - Otherwise the timer increments; on its TIMEOUT-th cycle in the state the FSM goes to FAIL.
  - DNSResp on the timeout cycle wins.
- VERIFY_DNS: DNSOk=1 goes to SEND_SERVER, else FAIL.
- SEND_SERVER: 1 cycle, then AWAIT; the timer clears.
- AWAIT:
  - ServerResp=1 goes to GET_RESP.
  - On timeout with retry<MAX_RETRY, retry increments and state goes to SEND_SERVER.
  - On timeout with retry==MAX_RETRY, state goes to FAIL.
  - ServerResp on the timeout cycle wins.
- GET_RESP: 1 cycle, then VERIFY_PKT.
- VERIFY_PKT: PktOk=1 goes to DELIVER, else FAIL.
- DELIVER: DeviceResp[GrantId]=1 for 1 cycle, then IDLE; the retry counter clears.
- CANCEL and FAIL: 1 cycle each, then IDLE; the retry counter clears.
- Cancel rule:
  - In GET_REQ through VERIFY_PKT inclusive, DeviceReq[GrantId]==0 sends the FSM to CANCEL.
  - Cancel has priority over every other transition, including a simultaneous response or timeout.
  - Requests on other channels never affect the current transaction.
- DELIVER is not cancellable. A request dropped in DELIVER still receives its pulse.
- Back-to-back: from IDLE, a new grant occurs on the first IDLE cycle a request is present. There is no extra idle gap.
- Starvation freedom: with all channels requesting continuously, grants rotate 0,1,2,3,0…
- DNSOk and PktOk are don't-care outside their verify states.

Decomposition:
- Package router_pkg holds:
  - the state_t enum: IDLE, GET_REQ, DNS_QUERY, VERIFY_DNS, SEND_SERVER, AWAIT, GET_RESP, VERIFY_PKT, DELIVER, CANCEL, FAIL;
  - shared defaults for N_CH, TIMEOUT and MAX_RETRY.
- Sub-module rr_arbiter: parameterised by N_CH; takes the request vector, ptr and an enable; returns a one-hot grant and an encoded index. It is purely combinational, and ptr is held in router_mc.

Test Plan:
(Parameters for all cases: N_CH=4, TIMEOUT=4, MAX_RETRY=1.)
1. Full path: reset, then DeviceReq=4'b0100 held; DNSResp=DNSOk=1 in DNS_QUERY; ServerResp=PktOk=1 in AWAIT. Expect GrantId=2, DNSReq high 1 cycle, one ServerReq pulse, DeviceResp=4'b0100 for exactly 1 cycle, then IDLE.
2. Round robin: DeviceReq=4'b1111 held; each transaction completes as in case 1. Expect grant order 0,1,2,3,0, with no IDLE cycles beyond one per transaction.
3. Cancel: grant channel 1. Drop DeviceReq[1] in the same cycle ServerResp=1 while in AWAIT. Expect CANCEL next, Cancelled=1 for 1 cycle, and DeviceResp stays 0.
4. Retry then fail: ServerResp held at 0. Expect AWAIT for 4 cycles, a second ServerReq pulse, AWAIT for 4 more cycles, then FAIL with Failed=1 for 1 cycle. ServerReq pulses exactly 2 times in total.
5. Verify failures: DNSOk=0 in VERIFY_DNS goes to FAIL. In a second transaction, PktOk=0 in VERIFY_PKT goes to FAIL. No DeviceResp is asserted in either case.
6. Reset mid-op: assert reset for 1 cycle while in AWAIT with retry=1. Next cycle expect State=IDLE, all outputs 0, and the first grant from 4'b1111 is channel 0.
